scan_frame_scheduler: RTL and testbench

- Sequences tactile-matrix acquisition: selects each switch/read wire pair, waits for settling, handshakes one ADC sample, and writes it to a ping-pong frame BRAM.
- On frame completion, launches the convolution engine on the just-filled bank with a latched kernel select, while scanning continues into the other bank.
- Sits between the ADC front end, frame BRAM write port and the convolution computation block.

---
 rtl/scan_frame_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_scan_frame_scheduler.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_frame_scheduler.sv
// Tactile-matrix scan sequencer: settles each switch/read wire pair, handshakes one ADC sample
// into a ping-pong frame BRAM, and launches convolution per finished bank. Option: SCAN_TIMEOUT_EN.
module scan_frame_scheduler #(
  parameter int SW_WIRE_CNT   = 16,
  parameter int RD_WIRE_CNT   = 16,
  parameter int SETTLE_CYCLES = 32,
  parameter int ADC_TIMEOUT   = 255
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     continuous,
  input  logic [2:0]                               k_select_in,
  output logic                                     adc_req,
  input  logic                                     adc_valid,
  input  logic [11:0]                              adc_data,
  output logic [$clog2(SW_WIRE_CNT)-1:0]           sw_sel,
  output logic [$clog2(RD_WIRE_CNT)-1:0]           rd_sel,
  output logic                                     wr_en,
  output logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT):0] wr_addr,
  output logic [11:0]                              wr_data,
  output logic                                     conv_start,
  output logic                                     conv_bank,
  output logic [2:0]                               k_select,
  input  logic                                     conv_done,
  output logic                                     busy,
  output logic [15:0]                              frame_cnt,
  output logic                                     overrun,
  output logic                                     adc_timeout
);

  localparam int SW_W  = $clog2(SW_WIRE_CNT);
  localparam int RD_W  = $clog2(RD_WIRE_CNT);
  localparam int LIN_W = $clog2(SW_WIRE_CNT * RD_WIRE_CNT);
  localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);

  if (SETTLE_CYCLES < 1 || ADC_TIMEOUT < 1) begin : g_param_check
    $error("scan_frame_scheduler: SETTLE_CYCLES and ADC_TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CONVERT,
    S_WRITE,
    S_FRAME_DONE,
    S_HOLD
  } state_t;

  state_t            r_state;
  logic [ST_W-1:0]   r_settleCnt;
  logic              r_bank;
  logic              r_convBusy;

  logic              w_lastTaxel;
  logic [LIN_W-1:0]  w_linAddr;
  logic              w_launch;
  logic [2:0]        w_kSel;
  logic              w_capture;
  logic [11:0]       w_capData;

`ifdef SCAN_TIMEOUT_EN
  localparam int TO_W = $clog2(ADC_TIMEOUT + 1);
  logic [TO_W-1:0]   r_toCnt;
  logic              r_adcTimeout;
  assign adc_timeout = r_adcTimeout;
`else
  assign adc_timeout = 1'b0;
`endif

  always_comb begin
    w_lastTaxel = (sw_sel == SW_W'(SW_WIRE_CNT - 1)) && (rd_sel == RD_W'(RD_WIRE_CNT - 1));
    w_linAddr   = LIN_W'(int'(sw_sel) * RD_WIRE_CNT + int'(rd_sel));
    // HOLD launches on the very cycle conv_done arrives; FRAME_DONE only when the engine is idle
    w_launch    = ((r_state == S_FRAME_DONE) && !r_convBusy) ||
                  ((r_state == S_HOLD) && conv_done);
    w_kSel      = (k_select_in > 3'd5) ? 3'd0 : k_select_in;
    w_capture   = 1'b0;
    w_capData   = adc_data;
    if (r_state == S_CONVERT) begin
      if (adc_valid) begin
        w_capture = 1'b1;
      end
`ifdef SCAN_TIMEOUT_EN
      else if (r_toCnt == TO_W'(ADC_TIMEOUT - 1)) begin
        w_capture = 1'b1;
        w_capData = 12'hFFF;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_settleCnt <= '0;
      r_bank      <= 1'b0;
      r_convBusy  <= 1'b0;
      adc_req     <= 1'b0;
      sw_sel      <= '0;
      rd_sel      <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      conv_start  <= 1'b0;
      conv_bank   <= 1'b0;
      k_select    <= 3'd0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
      r_toCnt      <= '0;
      r_adcTimeout <= 1'b0;
`endif
    end else begin
      wr_en      <= 1'b0;
      conv_start <= 1'b0;
      if (conv_done) begin
        r_convBusy <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_SELECT;
            busy        <= 1'b1;
            r_settleCnt <= '0;
          end
        end
        S_SELECT: begin
          if (r_settleCnt == ST_W'(SETTLE_CYCLES - 1)) begin
            r_state <= S_CONVERT;
            adc_req <= 1'b1;
`ifdef SCAN_TIMEOUT_EN
            r_toCnt <= '0;
`endif
          end else begin
            r_settleCnt <= r_settleCnt + 1'b1;
          end
        end
        S_CONVERT: begin
          if (w_capture) begin
            adc_req <= 1'b0;
            wr_en   <= 1'b1;
            wr_addr <= {r_bank, w_linAddr};
            wr_data <= w_capData;
            r_state <= S_WRITE;
`ifdef SCAN_TIMEOUT_EN
            if (!adc_valid) begin
              r_adcTimeout <= 1'b1;
            end
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
`endif
          end
        end
        S_WRITE: begin
          r_settleCnt <= '0;
          if (w_lastTaxel) begin
            r_state <= S_FRAME_DONE;
          end else begin
            r_state <= S_SELECT;
            if (rd_sel == RD_W'(RD_WIRE_CNT - 1)) begin
              rd_sel <= '0;
              sw_sel <= sw_sel + 1'b1;
            end else begin
              rd_sel <= rd_sel + 1'b1;
            end
          end
        end
        S_FRAME_DONE: begin
          frame_cnt <= frame_cnt + 1'b1;
          if (r_convBusy) begin
            overrun <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
        end
        default: r_state <= S_IDLE;
      endcase

      // Launch hands the filled bank to the engine and restarts the scan in the other bank
      if (w_launch) begin
        conv_start  <= 1'b1;
        conv_bank   <= r_bank;
        k_select    <= w_kSel;
        r_convBusy  <= 1'b1;
        r_bank      <= ~r_bank;
        sw_sel      <= '0;
        rd_sel      <= '0;
        r_settleCnt <= '0;
        if (continuous) begin
          r_state <= S_SELECT;
        end else begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_frame_scheduler.sv
// Directed bench for scan_frame_scheduler (SW=4, RD=4, SETTLE=2, ADC_TIMEOUT=8); the timeout
// scenario only runs when SCAN_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_scan_frame_scheduler;
  localparam int SW = 4, RD = 4, SETTLE = 2, TOUT = 8;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, continuous = 1'b0;
  logic [2:0]  k_select_in = 3'd0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic        conv_done = 1'b0;
  logic        adc_req, wr_en, conv_start, conv_bank, busy, overrun, adc_timeout;
  logic [1:0]  sw_sel, rd_sel;
  logic [4:0]  wr_addr;
  logic [11:0] wr_data;
  logic [2:0]  k_select;
  logic [15:0] frame_cnt;

  int checks = 0, failures = 0;
  int cyc = 0, startCyc = 0;
  int wrAddrQ[$], wrDataQ[$], wrCycQ[$], csCycQ[$], csBankQ[$], csKselQ[$];
  int wBase = 0, cBase = 0;
  int respDelay = 0, suppressIdx = -1, reqBase = 0, reqIdx = 0, waitCnt = 0, curEpi = 0;
  bit prevReq = 1'b0;
  int doneTimer = 0, doneReq = 0, doneAck = 0, doneCyc = 0;
  bit autoDone = 1'b1;

  scan_frame_scheduler #(
    .SW_WIRE_CNT(SW), .RD_WIRE_CNT(RD), .SETTLE_CYCLES(SETTLE), .ADC_TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .k_select_in(k_select_in),
    .adc_req(adc_req), .adc_valid(adc_valid), .adc_data(adc_data),
    .sw_sel(sw_sel), .rd_sel(rd_sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .conv_start(conv_start), .conv_bank(conv_bank), .k_select(k_select), .conv_done(conv_done),
    .busy(busy), .frame_cnt(frame_cnt), .overrun(overrun), .adc_timeout(adc_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records every write strobe and launch with the cycle it appeared in
  initial forever begin
    @(negedge clk);
    if (wr_en) begin
      wrAddrQ.push_back(int'(wr_addr));
      wrDataQ.push_back(int'(wr_data));
      wrCycQ.push_back(cyc);
    end
    if (conv_start) begin
      csCycQ.push_back(cyc);
      csBankQ.push_back(int'(conv_bank));
      csKselQ.push_back(int'(k_select));
    end
  end

  // ADC model: answers each request episode respDelay cycles late with data 0x100 + episode index
  initial forever begin
    @(negedge clk);
    if (adc_req) begin
      if (!prevReq) begin
        curEpi  = reqIdx - reqBase;
        reqIdx  = reqIdx + 1;
        waitCnt = 0;
      end
      if (curEpi != suppressIdx && waitCnt == respDelay) begin
        adc_valid = 1'b1;
        adc_data  = 12'(12'h100 + curEpi);
      end else begin
        adc_valid = 1'b0;
        waitCnt   = waitCnt + 1;
      end
    end else begin
      adc_valid = 1'b0;
    end
    prevReq = adc_req;
  end

  // Convolution model: auto-completes 10 cycles after a launch, or pulses on request
  initial forever begin
    @(negedge clk);
    conv_done = 1'b0;
    if (doneReq != doneAck) begin
      conv_done = 1'b1;
      doneAck   = doneReq;
      doneCyc   = cyc;
    end else if (autoDone) begin
      if (conv_start) begin
        doneTimer = 10;
      end else if (doneTimer > 0) begin
        doneTimer = doneTimer - 1;
        if (doneTimer == 0) begin
          conv_done = 1'b1;
          doneCyc   = cyc;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; continuous = 1'b0; suppressIdx = -1; respDelay = 0; autoDone = 1'b1;
    repeat (2) @(negedge clk);
    reqBase = reqIdx; wBase = wrAddrQ.size(); cBase = csCycQ.size();
    rst = 1'b1;
  endtask

  task automatic startPulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    startCyc = cyc;
  endtask

  task automatic waitBusyLow(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitWrites(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wrAddrQ.size() - wBase >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitLaunches(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (csCycQ.size() - cBase >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({adc_req, sw_sel, rd_sel, wr_en, wr_addr, wr_data, conv_start, conv_bank, k_select,
         busy, frame_cnt, overrun, adc_timeout} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got wr_addr=%0h busy=%0b frame_cnt=%0d expected all zero",
               wr_addr, busy, frame_cnt);
    end
    applyReset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || adc_req !== 1'b0) begin
      failures++; $display("[TB] FAIL idle_after_reset: got busy=%0b adc_req=%0b expected 0", busy, adc_req);
    end
  endtask

  task automatic test_single_frame();
    bit ok; int n, firstStart;
    applyReset();
    k_select_in = 3'd3;
    startPulse();
    firstStart = startCyc;
    waitWrites(5, 100, ok);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    waitBusyLow(200, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL single_idle: got busy expected idle within 200"); end
    repeat (20) @(negedge clk);
    n = wrAddrQ.size() - wBase;
    checks++;
    if (n !== 16) begin failures++; $display("[TB] FAIL single_count: got %0d expected 16", n); end
    for (int k = 0; k < n && k < 16; k++) begin
      checks++;
      if (wrAddrQ[wBase+k] !== k || wrDataQ[wBase+k] !== 32'h100 + k) begin
        failures++;
        $display("[TB] FAIL single_write%0d: got addr=%0d data=%0h expected addr=%0d data=%0h",
                 k, wrAddrQ[wBase+k], wrDataQ[wBase+k], k, 32'h100 + k);
      end
      if (k > 0) begin
        checks++;
        if (wrCycQ[wBase+k] - wrCycQ[wBase+k-1] !== SETTLE + 2) begin
          failures++;
          $display("[TB] FAIL single_spacing%0d: got %0d expected %0d", k,
                   wrCycQ[wBase+k] - wrCycQ[wBase+k-1], SETTLE + 2);
        end
      end
    end
    checks++;
    if (n > 0 && wrCycQ[wBase] - firstStart !== SETTLE + 1) begin
      failures++; $display("[TB] FAIL first_latency: got %0d expected %0d", wrCycQ[wBase] - firstStart, SETTLE + 1);
    end
    checks++;
    if (csCycQ.size() - cBase !== 1) begin
      failures++; $display("[TB] FAIL single_launches: got %0d expected 1", csCycQ.size() - cBase);
    end else begin
      checks++;
      if (csBankQ[cBase] !== 0 || csKselQ[cBase] !== 3 || (n == 16 && csCycQ[cBase] !== wrCycQ[wBase+15] + 2)) begin
        failures++;
        $display("[TB] FAIL single_launch: got bank=%0d ksel=%0d cyc=%0d expected bank=0 ksel=3 cyc=last+2",
                 csBankQ[cBase], csKselQ[cBase], csCycQ[cBase]);
      end
    end
    checks++;
    if (frame_cnt !== 16'd1 || overrun !== 1'b0 || adc_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_status: got frame_cnt=%0d overrun=%0b adc_timeout=%0b expected 1,0,0",
               frame_cnt, overrun, adc_timeout);
    end
  endtask

  task automatic test_adc_latency();
    bit ok; int n;
    applyReset();
    respDelay = 2;
    startPulse();
    waitBusyLow(300, ok);
    n = wrAddrQ.size() - wBase;
    checks++;
    if (!ok || n !== 16) begin failures++; $display("[TB] FAIL latency_count: got %0d expected 16", n); end
    for (int k = 1; k < n && k < 4; k++) begin
      checks++;
      if (wrCycQ[wBase+k] - wrCycQ[wBase+k-1] !== SETTLE + 3 + 1) begin
        failures++;
        $display("[TB] FAIL latency_spacing%0d: got %0d expected %0d", k,
                 wrCycQ[wBase+k] - wrCycQ[wBase+k-1], SETTLE + 4);
      end
    end
  endtask

  task automatic test_continuous();
    bit ok; int n, expAddr;
    applyReset();
    continuous = 1'b1; k_select_in = 3'd2;
    startPulse();
    waitLaunches(2, 400, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL cont_launches: got timeout expected 2 launches"); end
    continuous = 1'b0;
    waitBusyLow(300, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL cont_idle: got busy expected idle"); end
    n = wrAddrQ.size() - wBase;
    checks++;
    if (n !== 48) begin failures++; $display("[TB] FAIL cont_count: got %0d expected 48", n); end
    for (int k = 0; k < n && k < 48; k++) begin
      expAddr = (k < 32) ? k : k - 32;
      checks++;
      if (wrAddrQ[wBase+k] !== expAddr || wrDataQ[wBase+k] !== 32'h100 + k) begin
        failures++;
        $display("[TB] FAIL cont_write%0d: got addr=%0d data=%0h expected addr=%0d data=%0h",
                 k, wrAddrQ[wBase+k], wrDataQ[wBase+k], expAddr, 32'h100 + k);
      end
    end
    checks++;
    if (csCycQ.size() - cBase !== 3) begin
      failures++; $display("[TB] FAIL cont_launch_count: got %0d expected 3", csCycQ.size() - cBase);
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (csBankQ[cBase+j] !== (j % 2)) begin
          failures++; $display("[TB] FAIL cont_bank%0d: got %0d expected %0d", j, csBankQ[cBase+j], j % 2);
        end
      end
      checks++;
      if (n >= 17 && wrCycQ[wBase+16] !== csCycQ[cBase] + SETTLE + 1) begin
        failures++;
        $display("[TB] FAIL cont_restart: got %0d expected %0d", wrCycQ[wBase+16], csCycQ[cBase] + SETTLE + 1);
      end
    end
    checks++;
    if (overrun !== 1'b0 || frame_cnt !== 16'd3) begin
      failures++; $display("[TB] FAIL cont_status: got overrun=%0b frame_cnt=%0d expected 0,3", overrun, frame_cnt);
    end
  endtask

  task automatic test_overrun_hold();
    bit ok;
    applyReset();
    autoDone = 1'b0; continuous = 1'b1; k_select_in = 3'd3;
    startPulse();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (overrun) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL hold_overrun: got 0 expected 1"); end
    k_select_in = 3'd7;
    repeat (5) @(negedge clk);
    checks++;
    if (csCycQ.size() - cBase !== 1 || frame_cnt !== 16'd2 || busy !== 1'b1 || wrAddrQ.size() - wBase !== 32) begin
      failures++;
      $display("[TB] FAIL hold_state: got launches=%0d frame_cnt=%0d busy=%0b writes=%0d expected 1,2,1,32",
               csCycQ.size() - cBase, frame_cnt, busy, wrAddrQ.size() - wBase);
    end
    doneReq = doneReq + 1;
    waitLaunches(2, 10, ok);
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL hold_release: got no launch expected launch after conv_done");
    end else begin
      checks++;
      if (csCycQ[cBase+1] !== doneCyc + 1 || csBankQ[cBase+1] !== 1) begin
        failures++;
        $display("[TB] FAIL hold_launch: got cyc=%0d bank=%0d expected cyc=%0d bank=1",
                 csCycQ[cBase+1], csBankQ[cBase+1], doneCyc + 1);
      end
      checks++;
      if (csKselQ[cBase] !== 3 || csKselQ[cBase+1] !== 0) begin
        failures++;
        $display("[TB] FAIL kselect: got %0d,%0d expected 3,0", csKselQ[cBase], csKselQ[cBase+1]);
      end
    end
    checks++;
    if (frame_cnt !== 16'd2 || overrun !== 1'b1) begin
      failures++; $display("[TB] FAIL hold_after: got frame_cnt=%0d overrun=%0b expected 2,1", frame_cnt, overrun);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok; int n;
    applyReset();
    startPulse();
    waitWrites(9, 200, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL mid_reach: got timeout expected 9 writes"); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({adc_req, sw_sel, rd_sel, wr_en, wr_addr, wr_data, conv_start, busy, frame_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset: got sw=%0d rd=%0d busy=%0b wr_addr=%0d expected all zero",
               sw_sel, rd_sel, busy, wr_addr);
    end
    repeat (3) @(negedge clk);
    reqBase = reqIdx; wBase = wrAddrQ.size(); cBase = csCycQ.size();
    rst = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (csCycQ.size() - cBase !== 0 || wrAddrQ.size() - wBase !== 0) begin
      failures++; $display("[TB] FAIL mid_quiet: got launches=%0d expected 0", csCycQ.size() - cBase);
    end
    startPulse();
    waitBusyLow(200, ok);
    n = wrAddrQ.size() - wBase;
    checks++;
    if (n !== 16 || wrAddrQ[wBase] !== 0 || wrAddrQ[wBase+15] !== 15) begin
      failures++; $display("[TB] FAIL mid_rescan: got count=%0d expected 16 writes from addr 0", n);
    end
    checks++;
    if (csCycQ.size() - cBase !== 1 || csBankQ[cBase] !== 0) begin
      failures++; $display("[TB] FAIL mid_bank: got launches=%0d expected 1 on bank 0", csCycQ.size() - cBase);
    end
  endtask

`ifdef SCAN_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int n;
    applyReset();
    suppressIdx = 5;
    startPulse();
    waitBusyLow(300, ok);
    n = wrAddrQ.size() - wBase;
    checks++;
    if (!ok || n !== 16) begin failures++; $display("[TB] FAIL to_count: got %0d expected 16", n); end
    checks++;
    if (n > 6 && (wrAddrQ[wBase+5] !== 5 || wrDataQ[wBase+5] !== 32'hFFF)) begin
      failures++;
      $display("[TB] FAIL to_write: got addr=%0d data=%0h expected 5,fff", wrAddrQ[wBase+5], wrDataQ[wBase+5]);
    end
    checks++;
    if (n > 6 && wrCycQ[wBase+5] - wrCycQ[wBase+4] !== SETTLE + TOUT + 1) begin
      failures++;
      $display("[TB] FAIL to_spacing: got %0d expected %0d", wrCycQ[wBase+5] - wrCycQ[wBase+4], SETTLE + TOUT + 1);
    end
    checks++;
    if (adc_timeout !== 1'b1 || csCycQ.size() - cBase !== 1) begin
      failures++; $display("[TB] FAIL to_flag: got adc_timeout=%0b expected 1", adc_timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_adc_latency();
    test_continuous();
    test_overrun_hold();
    test_reset_midframe();
`ifdef SCAN_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
